// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side packer.
//   FIFO_DSIZE      - default FIFO entry width in bits
//   rd_pack_state_t - packer FSM state (S_FILL accumulates, S_FLUSH closes a partial word)
//   keep_mask()     - low-order mask with 'cnt' bits set, used as lane keep bits
package fifo_pkg;

    localparam int FIFO_DSIZE = 8;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } rd_pack_state_t;

    // Mask of 'cnt' contiguous ones starting at bit 0; saturates at 32 lanes.
    function automatic logic [31:0] keep_mask(input int unsigned cnt);
        logic [31:0] mask_v;
        if (cnt >= 32'd32) begin
            mask_v = 32'hFFFF_FFFF;
        end else begin
            mask_v = (32'd1 << cnt) - 32'd1;
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_slot.sv
// pack_out_slot: one-entry output register for the packed wide stream.
// Ports:
//   rclk, rrst          - read-domain clock, synchronous active-high reset
//   load                - capture load_data/load_keep this edge (only when slot_free)
//   load_data/load_keep - word and lane-keep bits to present downstream
//   m_ready             - downstream accept
//   m_valid/m_data/m_keep - registered output word
//   slot_free           - slot can accept a load this cycle (empty or draining)
module pack_out_slot #(
    parameter int OSIZE = 32,
    parameter int PACK  = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             load,
    input  logic [OSIZE-1:0] load_data,
    input  logic [PACK-1:0]  load_keep,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [OSIZE-1:0] m_data,
    output logic [PACK-1:0]  m_keep,
    output logic             slot_free
);

    logic             valid_r;
    logic [OSIZE-1:0] data_r;
    logic [PACK-1:0]  keep_r;

    // A held word may be replaced in the same cycle it is accepted downstream.
    assign slot_free = !valid_r || m_ready;

    // Output register: load wins over drain; data/keep only change on a load.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            valid_r <= 1'b0;
            data_r  <= {OSIZE{1'b0}};
            keep_r  <= {PACK{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
        end else if (valid_r && m_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign m_valid = valid_r;
    assign m_data  = data_r;
    assign m_keep  = keep_r;

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains DSIZE-wide entries from a first-word-fall-through FIFO
// and packs PACK consecutive entries into one wide word with per-lane keep bits.
// A flush pulse closes a partially filled word early (empty words never emitted).
// Ports:
//   rclk, rrst  - read-domain clock, synchronous active-high reset
//   rdata       - FIFO head entry, valid while rempty=0
//   rempty      - FIFO empty flag
//   r_valid     - pop strobe to the FIFO (combinational, never set in reset or when empty)
//   flush       - single-cycle request to emit the current partial word
//   m_data      - packed word, entry 0 in the LSBs
//   m_keep      - lane i holds data when bit i is set
//   m_valid     - output word valid
//   m_ready     - downstream accept
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int PACK  = 4,
    parameter int OSIZE = DSIZE * PACK
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             r_valid,
    input  logic             flush,
    output logic [OSIZE-1:0] m_data,
    output logic [PACK-1:0]  m_keep,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PACK - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    rd_pack_state_t   state_r;
    rd_pack_state_t   next_state_s;
    logic [CW-1:0]    cnt_r;
    logic [OSIZE-1:0] acc_r;
    logic             slot_free_s;
    logic             last_lane_s;
    logic             pop_s;
    logic             flush_load_s;
    logic [OSIZE-1:0] full_word_s;
    logic             load_s;
    logic [OSIZE-1:0] load_data_s;
    logic [PACK-1:0]  load_keep_s;

    assign last_lane_s  = (cnt_r == LAST_CNT);
    assign flush_load_s = (state_r == S_FLUSH) && (cnt_r != CNT_ZERO) && slot_free_s;

    // Pop decision: the final lane may only be taken when the slot can accept the word.
    always_comb begin
        pop_s = 1'b0;
        if (rrst) begin
            pop_s = 1'b0;
        end else if (state_r == S_FILL) begin
            pop_s = !rempty && (!last_lane_s || slot_free_s);
        end else begin
            pop_s = 1'b0;
        end
    end

    assign r_valid = pop_s;

    // Accumulator with the current head merged into lane cnt (word completed by a pop).
    always_comb begin
        full_word_s = acc_r;
        full_word_s[int'(cnt_r) * DSIZE +: DSIZE] = rdata;
    end

    // Output-slot load: a completing pop fills all lanes; a flush emits only filled lanes.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = {OSIZE{1'b0}};
        load_keep_s = {PACK{1'b0}};
        if (pop_s && last_lane_s) begin
            load_s      = 1'b1;
            load_data_s = full_word_s;
            load_keep_s = {PACK{1'b1}};
        end else if (flush_load_s) begin
            load_s      = 1'b1;
            load_data_s = acc_r;
            load_keep_s = PACK'(keep_mask(32'(cnt_r)));
        end else begin
            load_s      = 1'b0;
        end
    end

    // Next-state: flush while filling is latched; flush while flushing is ignored.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FILL: begin
                if (flush) begin
                    next_state_s = S_FLUSH;
                end else begin
                    next_state_s = S_FILL;
                end
            end
            S_FLUSH: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = S_FILL;
                end else if (slot_free_s) begin
                    next_state_s = S_FILL;
                end else begin
                    next_state_s = S_FLUSH;
                end
            end
            default: begin
                next_state_s = S_FILL;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r <= S_FILL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fill counter and lane accumulator; cleared whenever a word leaves for the slot.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_r <= CNT_ZERO;
            acc_r <= {OSIZE{1'b0}};
        end else if (pop_s) begin
            if (last_lane_s) begin
                cnt_r <= CNT_ZERO;
                acc_r <= {OSIZE{1'b0}};
            end else begin
                acc_r[int'(cnt_r) * DSIZE +: DSIZE] <= rdata;
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (flush_load_s) begin
            cnt_r <= CNT_ZERO;
            acc_r <= {OSIZE{1'b0}};
        end
    end

    pack_out_slot #(
        .OSIZE (OSIZE),
        .PACK  (PACK)
    ) u_slot (
        .rclk      (rclk),
        .rrst      (rrst),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .slot_free (slot_free_s)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue models the FIFO, every popped byte is appended
// to an expected stream, and every accepted output word must consume the next bytes
// of that stream in lane order (unkept lanes zero, keep contiguous from lane 0).
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;
    localparam int OSIZE = DSIZE * PACK;

    logic             rclk = 1'b0;
    logic             rrst;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             r_valid;
    logic             flush;
    logic [OSIZE-1:0] m_data;
    logic [PACK-1:0]  m_keep;
    logic             m_valid;
    logic             m_ready;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .r_valid (r_valid),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  q[$];
    logic [7:0]  exp_stream[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    bit          hold_empty = 1'b0;
    bit          last_pop, last_hs;

    bit          prev_v = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_d;
    logic [3:0]  prev_k;

    task automatic drive_fifo();
        rempty = hold_empty || (q.size() == 0);
        rdata  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // One clock: sample at negedge, update the model just after the posedge.
    task automatic tick();
        bit p, v, hs, rs;
        logic [31:0] d;
        logic [3:0]  k;
        logic [7:0]  e;
        @(negedge rclk);
        p  = (r_valid === 1'b1);
        v  = (m_valid === 1'b1);
        hs = v && (m_ready === 1'b1);
        d  = m_data;
        k  = m_keep;
        rs = rrst;
        if (rempty || rrst) begin
            total++;
            if (r_valid !== 1'b0) begin
                bad++;
                $display("FAIL rvalid_illegal: r_valid=%b rempty=%b rrst=%b required r_valid=0",
                         r_valid, rempty, rrst);
            end
        end
        if (prev_v && !prev_hs && !prev_rst) begin
            total++;
            if (!v || d !== prev_d || k !== prev_k) begin
                bad++;
                $display("FAIL hold_stable: valid=%b data=%h keep=%b required valid=1 data=%h keep=%b",
                         v, d, k, prev_d, prev_k);
            end
        end
        prev_v = v; prev_hs = hs; prev_rst = rs; prev_d = d; prev_k = k;
        @(posedge rclk);
        #1;
        if (p) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pop_underflow: popped with model FIFO empty");
            end else begin
                exp_stream.push_back(q.pop_front());
            end
        end
        if (hs) begin
            got_d.push_back(d);
            got_k.push_back(k);
            total++;
            if (!(k inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
                bad++;
                $display("FAIL keep_shape: keep=%b required contiguous nonzero from lane 0", k);
            end
            for (int i = 0; i < PACK; i++) begin
                total++;
                if (k[i]) begin
                    if (exp_stream.size() == 0) begin
                        bad++;
                        $display("FAIL lane_extra: lane %0d=%h required no data (stream empty)", i, d[i*8 +: 8]);
                    end else begin
                        e = exp_stream.pop_front();
                        if (d[i*8 +: 8] !== e) begin
                            bad++;
                            $display("FAIL lane_data: lane %0d=%h required %h", i, d[i*8 +: 8], e);
                        end
                    end
                end else if (d[i*8 +: 8] !== 8'h00) begin
                    bad++;
                    $display("FAIL lane_zero: lane %0d=%h required 00", i, d[i*8 +: 8]);
                end
            end
        end
        last_pop = p;
        last_hs  = hs;
        drive_fifo();
    endtask

    task automatic test_reset();
        rrst = 1'b1; m_ready = 1'b0; flush = 1'b0;
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive_fifo();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (last_pop) begin
                bad++;
                $display("FAIL reset_rvalid: r_valid=1 in reset cycle %0d required 0", i);
            end
        end
        rrst = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid: %b required 0", m_valid); end
        total++;
        if (m_data !== 32'h0) begin bad++; $display("FAIL reset_mdata: %h required 00000000", m_data); end
        total++;
        if (m_keep !== 4'h0) begin bad++; $display("FAIL reset_mkeep: %b required 0000", m_keep); end
        q.delete();
        drive_fifo();
    endtask

    task automatic test_full_word();
        bit [7:0] pm, hm;
        int n0;
        pm = 8'h00; hm = 8'h00; n0 = got_d.size();
        m_ready = 1'b1;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_fifo();
        for (int i = 0; i < 7; i++) begin
            tick();
            pm[i] = last_pop;
            hm[i] = last_hs;
        end
        total++;
        if (pm !== 8'h0F) begin bad++; $display("FAIL full_pops: mask=%b required 00001111", pm); end
        total++;
        if (hm !== 8'h10) begin bad++; $display("FAIL full_latency: mask=%b required 00010000", hm); end
        total++;
        if (got_d.size() != n0 + 1 || got_d[got_d.size()-1] !== 32'h44332211 || got_k[got_k.size()-1] !== 4'hF) begin
            bad++;
            $display("FAIL full_word: words=%0d last=%h/%b required 1 word 44332211/1111",
                     got_d.size() - n0, got_d[got_d.size()-1], got_k[got_k.size()-1]);
        end
    endtask

    task automatic test_partial_flush();
        bit [7:0] hm;
        int n0;
        m_ready = 1'b1;
        q = '{8'hA1, 8'hB2};
        drive_fifo();
        for (int i = 0; i < 3; i++) tick();
        hm = 8'h00; n0 = got_d.size();
        flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            flush = 1'b0;
            hm[i] = last_hs;
        end
        total++;
        if (hm !== 8'h04) begin bad++; $display("FAIL flush_latency: mask=%b required 00000100", hm); end
        total++;
        if (got_d.size() != n0 + 1 || got_d[got_d.size()-1] !== 32'h0000B2A1 || got_k[got_k.size()-1] !== 4'h3) begin
            bad++;
            $display("FAIL flush_partial: words=%0d last=%h/%b required 1 word 0000b2a1/0011",
                     got_d.size() - n0, got_d[got_d.size()-1], got_k[got_k.size()-1]);
        end
        hm = 8'h00;
        flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            flush = 1'b0;
            hm[i] = last_hs;
        end
        total++;
        if (hm !== 8'h00) begin bad++; $display("FAIL flush_empty: handshakes=%b required none", hm); end
    endtask

    task automatic test_flush_with_pop();
        int n0;
        m_ready = 1'b1;
        q = '{8'h3A, 8'h4B};
        drive_fifo();
        tick(); tick();
        n0 = got_d.size();
        q.push_back(8'h5C);
        drive_fifo();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (got_d.size() != n0 + 1 || got_d[got_d.size()-1] !== 32'h005C4B3A || got_k[got_k.size()-1] !== 4'h7) begin
            bad++;
            $display("FAIL flush_pop_cnt2: words=%0d last=%h/%b required 1 word 005c4b3a/0111",
                     got_d.size() - n0, got_d[got_d.size()-1], got_k[got_k.size()-1]);
        end
        q = '{8'h61, 8'h62, 8'h63};
        drive_fifo();
        for (int i = 0; i < 3; i++) tick();
        n0 = got_d.size();
        q.push_back(8'h64);
        drive_fifo();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (got_d.size() != n0 + 1 || got_d[got_d.size()-1] !== 32'h64636261 || got_k[got_k.size()-1] !== 4'hF) begin
            bad++;
            $display("FAIL flush_pop_cnt3: words=%0d last=%h/%b required 1 word 64636261/1111",
                     got_d.size() - n0, got_d[got_d.size()-1], got_k[got_k.size()-1]);
        end
    endtask

    task automatic test_backpressure();
        int npop, n0;
        bit [15:0] pm, hm;
        npop = 0; pm = 16'h0; hm = 16'h0;
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h80 + i));
        drive_fifo();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_pop) npop++;
        end
        total++;
        if (npop != 7) begin bad++; $display("FAIL bp_pops: %0d required 7", npop); end
        total++;
        if (last_pop || rempty) begin bad++; $display("FAIL bp_stall: pop=%b rempty=%b required pop=0 rempty=0", last_pop, rempty); end
        n0 = got_d.size();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pm[i] = last_pop;
            hm[i] = last_hs;
        end
        total++;
        if (pm !== 16'h001F) begin bad++; $display("FAIL bp_pop_stream: mask=%b required 0000000000011111", pm); end
        total++;
        if (hm !== 16'h0023) begin bad++; $display("FAIL bp_words: mask=%b required 0000000000100011", hm); end
        total++;
        if (got_d.size() != n0 + 3 || got_d[n0] !== 32'h83828180 || got_d[n0+1] !== 32'h87868584 ||
            got_d[n0+2] !== 32'h8B8A8988) begin
            bad++;
            $display("FAIL bp_order: words=%0d required 3 words 83828180 87868584 8b8a8988", got_d.size() - n0);
        end
    endtask

    task automatic test_reset_mid_word();
        int n0;
        m_ready = 1'b1;
        q = '{8'hD1, 8'hD2};
        drive_fifo();
        tick(); tick();
        flush = 1'b1;
        rrst  = 1'b1;
        tick();
        rrst  = 1'b0;
        flush = 1'b0;
        exp_stream.delete();
        n0 = got_d.size();
        q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        drive_fifo();
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (got_d.size() != n0 + 1 || got_d[got_d.size()-1] !== 32'hE4E3E2E1 || got_k[got_k.size()-1] !== 4'hF) begin
            bad++;
            $display("FAIL reset_mid: words=%0d last=%h/%b required 1 word e4e3e2e1/1111",
                     got_d.size() - n0, got_d[got_d.size()-1], got_k[got_k.size()-1]);
        end
    endtask

    task automatic test_random_soak();
        int pushed;
        pushed = 0;
        for (int c = 0; c < 20000 && pushed < 1000; c++) begin
            if ($urandom_range(0, 2) != 0) begin
                q.push_back(8'($urandom_range(0, 255)));
                pushed++;
            end
            hold_empty = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            drive_fifo();
            tick();
        end
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        drive_fifo();
        for (int i = 0; i < 1000 && !(q.size() == 0 && exp_stream.size() == 0); i++) begin
            flush = (i % 4 == 0);
            tick();
        end
        flush = 1'b0;
        total++;
        if (pushed != 1000 || q.size() != 0 || exp_stream.size() != 0) begin
            bad++;
            $display("FAIL soak_drain: pushed=%0d fifo_left=%0d unemitted=%0d required 1000/0/0",
                     pushed, q.size(), exp_stream.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_flush();
        test_flush_with_pop();
        test_backpressure();
        test_reset_mid_word();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
